pipe_merge_arbiter: RTL and testbench
=====================================

# pipe_merge_arbiter

Merges the two 32-bit valid/data pipeline streams into one shared downstream output port. A bounded round-robin policy shares the port. Each pipeline gets a stall signal that freezes it whenever its current word is not taken. The block sits between the two pipeline tails and the shared sink inside `top`, and is the arbitration half of the global-stall scheme.

## Interface
- `DATA_W`, 32, data width of both inputs and the output
- `MAX_BURST`, 4, max consecutive words granted to one pipeline while the other is waiting (≥1)
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `in_data_1`  in  DATA_W  pipeline 1 word
- `in_valid_1`  in  1  pipeline 1 word present
- `stall_1`  out  1  pipeline 1 must hold its word this cycle
- `in_data_2`  in  DATA_W  pipeline 2 word
- `in_valid_2`  in  1  pipeline 2 word present
- `stall_2`  out  1  pipeline 2 must hold its word this cycle
- `out_data`  out  DATA_W  merged word (registered)
- `out_valid`  out  1  `out_data` valid (registered)
- `out_src`  out  1  source of `out_data`: 0 = pipeline 1, 1 = pipeline 2 (registered)
- `out_ready`  in  1  sink accepts `out_data` this cycle
- `stall_cnt_1`, `stall_cnt_2`  out  16  stall-cycle counters (only with `ARB_STATS_EN`)

## Operation
- FSM states: IDLE, OWN1, OWN2. Additional registers: `last` (last served source) and `burst` (0..MAX_BURST).
- `can_load = !out_valid || out_ready`.
- Selection, evaluated every cycle:
  - IDLE: both inputs valid → the source opposite `last`; otherwise the single valid source.
  - OWNx: keep x if `in_valid_x` and (other source not valid, or `burst < MAX_BURST`).
  - OWNx: switch to the other source if it is valid and (`in_valid_x`=0 or `burst == MAX_BURST`).
  - No valid input → no selection.
- `accept = selection exists && can_load`.
- On accept of source s, at the next edge:
  - `out_data` ← `in_data_s`, `out_valid` ← 1, `out_src` ← s, `last` ← s.
  - State ← OWNs.
  - `burst` ← `burst`+1 if s equals the current owner; otherwise 1. Saturates at MAX_BURST.
- No accept with `out_ready`=1 → `out_valid` ← 0.
- No valid input and `can_load` → state ← IDLE, `burst` ← 0.
- `stall_x = in_valid_x && !(accept && sel == x)`. This is combinational, with no register in the path.
- Upstream rule: while `stall_x`=1, the pipeline holds `in_data_x`/`in_valid_x` unchanged.
- Downstream full (`out_valid`=1, `out_ready`=0): both valid inputs stall. FSM, `burst` and the output register all hold.
- Fairness: with both sources continuously valid and `out_ready`=1, service alternates in runs of exactly MAX_BURST words.

## Timing
- Accept to `out_valid`: 1 cycle.
- Throughput: 1 word/cycle when `out_ready`=1 continuously.
- Reset values (asynchronous):
  - Registers: state IDLE, `last`=1 (pipeline 1 served first on a tie), `burst`=0.
  - Outputs: `out_data`=0, `out_valid`=0, `out_src`=0, stat counters=0.
  - `stall_1` and `stall_2` read 0 during reset; logic is gated by reset.
- Reset asserted mid-burst: the in-flight output word is discarded, and no word is duplicated after release.
- Simultaneous switch and downstream full: no switch occurs until `can_load`. The decision is re-evaluated on the cycle `can_load` rises.

## Configuration
- `ARB_STATS_EN` defined:
  - `stall_cnt_1` and `stall_cnt_2` ports exist.
  - Each increments by 1 on every cycle its stall signal is 1, saturating at 0xFFFF. Reset to 0.
- `ARB_STATS_EN` undefined: ports and counters are absent. Arbitration behaviour is identical.

## Structure
- Shared package `pipe_arb_pkg`:
  - `arb_state_t` enum (IDLE, OWN1, OWN2).
  - `SRC_P1`=0 and `SRC_P2`=1 constants.
  - `STALL_CNT_W`=16.
- One sub-module `arb_sat_counter` (width parameter, increment enable, saturating), instantiated twice under `ARB_STATS_EN`.
- FSM, selection and output register stay in `pipe_merge_arbiter`.

## Test plan
- Reset, then only pipeline 1 valid with data 1,2,3; `out_ready`=1 → `out_data` 1,2,3 on consecutive cycles starting 1 cycle after the first word; `out_src`=0; `stall_1`=0 throughout.
- Both valid continuously, `MAX_BURST`=4, `out_ready`=1 → `out_src` sequence 0,0,0,0,1,1,1,1,0…; the first word comes from pipeline 1.
- Both valid; `out_ready`=0 for 3 cycles after the first word → `out_valid`=1 with `out_data` held; `stall_1`=`stall_2`=1 for 3 cycles; no word lost or duplicated after `out_ready` returns.
- Pipeline 1 bursting; pipeline 2 becomes valid when `burst`=2 → pipeline 2 is served after the 4th pipeline-1 word, not before.
- Reset pulsed mid-stream → `out_valid`=0 immediately; after release the first tie goes to pipeline 1.
- With `ARB_STATS_EN`, pipeline 2 stalled 5 cycles → `stall_cnt_2`=5 and `stall_cnt_1` unchanged.

Source files
------------

// File: rtl/pipe_arb_pkg.sv
// Shared types and constants for the two-pipeline merge arbiter.
// Imported by pipe_merge_arbiter and arb_sat_counter.
package pipe_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN1 = 2'd1,
    OWN2 = 2'd2
  } arb_state_t;

  localparam logic SRC_P1 = 1'b0;
  localparam logic SRC_P2 = 1'b1;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter used for per-pipeline stall statistics.
// Sticks at all-ones instead of wrapping.
module arb_sat_counter
  import pipe_arb_pkg::*;
#(
  parameter int W = STALL_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // count enabled cycles, hold once every bit is set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_merge_arbiter.sv
// Bounded round-robin merge of two valid/data pipelines into one sink.
// Define ARB_STATS_EN to add the stall_cnt_1/stall_cnt_2 counters.
module pipe_merge_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic              in_valid_1,
  output logic              stall_1,
  input  logic [DATA_W-1:0] in_data_2,
  input  logic              in_valid_2,
  output logic              stall_2,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_src,
  input  logic              out_ready
`ifdef ARB_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt_1,
  output logic [STALL_CNT_W-1:0] stall_cnt_2
`endif
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

  arb_state_t    state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          last_q;
  logic          sel_vld, sel;
  logic          can_load, accept, same_owner;

  assign can_load = !out_valid || out_ready;
  assign accept   = sel_vld && can_load;

  assign same_owner =
    ((state_q == OWN1) && (sel == SRC_P1)) ||
    ((state_q == OWN2) && (sel == SRC_P2));

  // gated so both pipelines see no stall while held in reset
  assign stall_1 = !reset && in_valid_1 &&
                   !(accept && (sel == SRC_P1));
  assign stall_2 = !reset && in_valid_2 &&
                   !(accept && (sel == SRC_P2));

  // pick a source: keep the owner until its burst runs out
  always_comb begin
    sel_vld = 1'b0;
    sel     = SRC_P1;
    unique case (state_q)
      OWN1: begin
        if (in_valid_1 &&
            (!in_valid_2 || (burst_q < BMAX))) begin
          sel_vld = 1'b1;
          sel     = SRC_P1;
        end else if (in_valid_2) begin
          sel_vld = 1'b1;
          sel     = SRC_P2;
        end
      end
      OWN2: begin
        if (in_valid_2 &&
            (!in_valid_1 || (burst_q < BMAX))) begin
          sel_vld = 1'b1;
          sel     = SRC_P2;
        end else if (in_valid_1) begin
          sel_vld = 1'b1;
          sel     = SRC_P1;
        end
      end
      default: begin
        unique case (1'b1)
          in_valid_1 && in_valid_2: begin
            sel_vld = 1'b1;
            sel     = ~last_q;
          end
          in_valid_1 && !in_valid_2: begin
            sel_vld = 1'b1;
            sel     = SRC_P1;
          end
          !in_valid_1 && in_valid_2: begin
            sel_vld = 1'b1;
            sel     = SRC_P2;
          end
          default: begin
            sel_vld = 1'b0;
          end
        endcase
      end
    endcase
  end

  // ownership and burst length follow accepted words
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    if (accept) begin
      state_d = sel ? OWN2 : OWN1;
      if (!same_owner) begin
        burst_d = BW'(1);
      end else if (burst_q != BMAX) begin
        burst_d = burst_q + 1'b1;
      end
    end else if (!in_valid_1 && !in_valid_2 && can_load) begin
      state_d = IDLE;
      burst_d = '0;
    end
  end

  // arbiter state plus the registered output word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      burst_q   <= '0;
      last_q    <= SRC_P2;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_src   <= SRC_P1;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      if (accept) begin
        out_data  <= sel ? in_data_2 : in_data_1;
        out_valid <= 1'b1;
        out_src   <= sel;
        last_q    <= sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ARB_STATS_EN
  arb_sat_counter #(.W(STALL_CNT_W)) u_cnt_1 (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_1),
    .cnt   (stall_cnt_1)
  );

  arb_sat_counter #(.W(STALL_CNT_W)) u_cnt_2 (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_2),
    .cnt   (stall_cnt_2)
  );
`endif

endmodule

// File: tb/tb_pipe_merge_arbiter.sv
// Randomized bench for pipe_merge_arbiter against a behavioural model.
// Words carry {source, sequence} so loss or duplication shows up directly.
module tb_pipe_merge_arbiter;

  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] in_data_1, in_data_2, out_data;
  logic              in_valid_1, in_valid_2;
  logic              stall_1, stall_2;
  logic              out_valid, out_src, out_ready;
`ifdef ARB_STATS_EN
  logic [15:0]       stall_cnt_1, stall_cnt_2;
`endif

  pipe_merge_arbiter #(
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data_1  (in_data_1),
    .in_valid_1 (in_valid_1),
    .stall_1    (stall_1),
    .in_data_2  (in_data_2),
    .in_valid_2 (in_valid_2),
    .stall_2    (stall_2),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_src    (out_src),
    .out_ready  (out_ready)
`ifdef ARB_STATS_EN
    ,
    .stall_cnt_1 (stall_cnt_1),
    .stall_cnt_2 (stall_cnt_2)
`endif
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  // model: who owns the port, how long the current run is, last served
  int          m_owner, m_run, m_last;
  bit          m_valid, m_src;
  logic [31:0] m_data;
  int          sc1, sc2;

  int pct[2];
  int seq[2];
  int cons_next[2];
  int rdy_pct;
  bit obs_st1, obs_st2;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input bit v1, input bit v2);
    if (!v1 && !v2) return -1;
    if (v1 != v2) return v1 ? 0 : 1;
    if (m_owner < 0) return 1 - m_last;
    if (m_run >= MAX_BURST) return 1 - m_owner;
    return m_owner;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_run   = 0;
    m_last  = 1;
    m_valid = 0;
    m_src   = 0;
    m_data  = '0;
    sc1     = 0;
    sc2     = 0;
  endtask

  task automatic next_word(input int x);
    logic [31:0] d;
    bit          v;
    v = ($urandom_range(99) < pct[x]);
    if (v) seq[x]++;
    d = {x[0], 31'(seq[x])};
    if (x == 0) begin
      in_valid_1 = v;
      in_data_1  = d;
    end else begin
      in_valid_2 = v;
      in_data_2  = d;
    end
  endtask

  // re-present a pending word under new settings without losing its number
  task automatic refresh(input int x);
    if ((x == 0) ? in_valid_1 : in_valid_2) seq[x]--;
    next_word(x);
  endtask

  task automatic cycle();
    int          p;
    bit          v1, v2, cl, acc, s1, s2;
    logic [31:0] d1, d2;
    @(negedge clk);
    v1  = in_valid_1;
    v2  = in_valid_2;
    d1  = in_data_1;
    d2  = in_data_2;
    p   = pick(v1, v2);
    cl  = !m_valid || out_ready;
    acc = (p >= 0) && cl;
    s1  = v1 && !(acc && p == 0);
    s2  = v2 && !(acc && p == 1);
    obs_st1 = stall_1;
    obs_st2 = stall_2;
    check("stall_1", stall_1, s1);
    check("stall_2", stall_2, s2);
    if (out_valid && out_ready) begin
      check("order", out_data,
            {out_src, 31'(cons_next[int'(out_src)])});
      cons_next[int'(out_src)]++;
    end
    @(posedge clk);
    #1;
    if (acc) begin
      m_data  = (p == 0) ? d1 : d2;
      m_valid = 1;
      m_src   = p[0];
      m_last  = p;
      m_run   = (p == m_owner) ? m_run + 1 : 1;
      m_owner = p;
    end else begin
      if (out_ready) m_valid = 0;
      if (p < 0 && cl) begin
        m_owner = -1;
        m_run   = 0;
      end
    end
    check("out_valid", out_valid, m_valid);
    check("out_src", out_src, m_src);
    check("out_data", out_data, m_data);
`ifdef ARB_STATS_EN
    if (s1 && sc1 < 65535) sc1++;
    if (s2 && sc2 < 65535) sc2++;
    check("cnt_1", stall_cnt_1, sc1);
    check("cnt_2", stall_cnt_2, sc2);
`endif
    if (!s1) next_word(0);
    if (!s2) next_word(1);
    out_ready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic do_reset();
    if (m_valid) cons_next[m_src]++;
    #2 reset = 1'b1;
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_stall_1", stall_1, 1'b0);
    check("rst_stall_2", stall_2, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int src_log[9];
    logic [31:0] held;

    reset        = 1'b1;
    out_ready    = 1'b0;
    in_valid_1   = 1'b1;
    in_valid_2   = 1'b1;
    in_data_1    = 32'hdead;
    in_data_2    = 32'hbeef;
    seq          = '{0, 0};
    cons_next    = '{1, 1};
    model_reset();
    #3;
    check("init_valid", out_valid, 1'b0);
    check("init_data", out_data, 32'h0);
    check("init_src", out_src, 1'b0);
    check("init_stall_1", stall_1, 1'b0);
    check("init_stall_2", stall_2, 1'b0);
    @(posedge clk);
    #1;
    in_valid_1 = 1'b0;
    in_valid_2 = 1'b0;
    reset      = 1'b0;

    // single source streams back to back
    pct       = '{100, 0};
    rdy_pct   = 100;
    out_ready = 1'b1;
    refresh(0);
    refresh(1);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("t1_data", out_data, 32'(k + 1));
      check("t1_src", out_src, 1'b0);
      check("t1_valid", out_valid, 1'b1);
      check("t1_stall", obs_st1, 1'b0);
    end

    // fairness: runs of MAX_BURST, pipeline 1 first
    do_reset();
    pct = '{100, 100};
    refresh(0);
    refresh(1);
    for (int i = 0; i < 9; i++) begin
      cycle();
      check("fair_src", out_src, 32'((i / MAX_BURST) % 2));
    end

    // downstream full for three cycles
    do_reset();
    refresh(0);
    refresh(1);
    out_ready = 1'b1;
    rdy_pct   = 0;
    cycle();
    held = m_data;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) rdy_pct = 100;
      cycle();
      check("hold_data", out_data, held);
      check("hold_st1", obs_st1, 1'b1);
      check("hold_st2", obs_st2, 1'b1);
    end
    for (int i = 0; i < 6; i++) cycle();

    // late arrival of pipeline 2 waits for the burst to finish
    do_reset();
    pct = '{100, 0};
    refresh(0);
    refresh(1);
    cycle();
    pct[1] = 100;
    cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      src_log[i] = int'(out_src);
    end
    check("late_src3", src_log[0], 0);
    check("late_src4", src_log[1], 0);
    check("late_src5", src_log[2], 1);

    // reset in the middle of a busy stream
    rdy_pct = 70;
    for (int i = 0; i < 7; i++) cycle();
    do_reset();
    cycle();
    check("tie_after_rst", out_src, 1'b0);

`ifdef ARB_STATS_EN
    do_reset();
    pct = '{0, 100};
    refresh(0);
    refresh(1);
    out_ready = 1'b0;
    rdy_pct   = 0;
    for (int i = 0; i < 6; i++) cycle();
    check("stat_cnt_2", stall_cnt_2, 16'd5);
    check("stat_cnt_1", stall_cnt_1, 16'd0);
    rdy_pct = 100;
    cycle();
`endif

    // long random run with shifting load
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        pct[0]  = $urandom_range(100, 20);
        pct[1]  = $urandom_range(100, 20);
        rdy_pct = $urandom_range(100, 30);
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
